// File: rtl/i2c_bus_sched.sv
// Round-robin owner of one shared I2C master core on a multi-master bus; optional watchdog under `I2C_BUS_SCHED_WDOG_EN`.
// Latency: grant 1 cycle after the bus has been free BUF_CYC cycles; release 1 cycle after mst_done/arb_lost.
// Backpressure: req is a level held until gnt drops; no grant while the bus is busy or during arbitration-loss backoff.
module i2c_bus_sched #(
    parameter int NREQ     = 2,
    parameter int BUF_CYC  = 64,
    parameter int TOUT_CYC = 65536
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            bby,
    input  logic            sto,
    input  logic            mst_done,
    input  logic            arb_lost,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      owner,
    output logic            mst_go,
    output logic            lost,
    output logic            tout
);

    function automatic int clog2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int            IW      = clog2c(BUF_CYC + 1);
    localparam logic [IW-1:0] BUF_MAX = IW'(BUF_CYC);

    if (NREQ < 1 || NREQ > 8 || BUF_CYC < 1 || TOUT_CYC < 1) begin : g_param_check
        $error("i2c_bus_sched: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_BACKOFF = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [2:0]      last_q, last_d;
    logic [NREQ-1:0] gnt_d;
    logic [2:0]      owner_d;
    logic            mst_go_d, lost_d, tout_d;
    logic            grant_ok;
    logic            wd_hit;

    // Round-robin pick: first set request above the last owner, wrapping.
    logic [7:0] req8;
    logic [2:0] pick;
    logic       pick_found;
    logic [3:0] pos;

    assign req8 = 8'(req);

    always_comb begin
        pick       = last_q;
        pick_found = 1'b0;
        pos        = 4'd0;
        for (int i = 1; i <= NREQ; i++) begin
            pos = {1'b0, last_q} + 4'(i);
            if (pos >= 4'(NREQ)) pos = pos - 4'(NREQ);
            if (!pick_found && req8[pos[2:0]]) begin
                pick_found = 1'b1;
                pick       = pos[2:0];
            end
        end
    end

    assign grant_ok = (state_q == S_IDLE) && (|req) && !bby && (idle_cnt_q == BUF_MAX);

`ifdef I2C_BUS_SCHED_WDOG_EN
    localparam int WW = (clog2c(TOUT_CYC) < 1) ? 1 : clog2c(TOUT_CYC);
    logic [WW-1:0] wd_cnt_q;

    assign wd_hit = (state_q == S_ACTIVE) && (wd_cnt_q == WW'(TOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state_q != S_ACTIVE) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + WW'(1);
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idle_cnt_q <= '0;
            last_q     <= 3'(NREQ - 1);
            gnt        <= '0;
            owner      <= '0;
            mst_go     <= 1'b0;
            lost       <= 1'b0;
            tout       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            last_q     <= last_d;
            gnt        <= gnt_d;
            owner      <= owner_d;
            mst_go     <= mst_go_d;
            lost       <= lost_d;
            tout       <= tout_d;
        end
    end

    // Arbitration loss outranks completion, which outranks the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ok) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (arb_lost)      state_d = S_BACKOFF;
                else if (mst_done) state_d = S_IDLE;
                else if (wd_hit)   state_d = S_BACKOFF;
            end
            S_BACKOFF: begin
                if (sto || !bby) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = gnt;
        owner_d    = owner;
        mst_go_d   = 1'b0;
        lost_d     = 1'b0;
        tout_d     = 1'b0;
        last_d     = last_q;
        idle_cnt_d = '0;

        if (state_q == S_IDLE && !bby) begin
            idle_cnt_d = (idle_cnt_q == BUF_MAX) ? BUF_MAX : idle_cnt_q + IW'(1);
        end

        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (grant_ok) begin
                    gnt_d    = NREQ'(1) << pick;
                    owner_d  = pick;
                    mst_go_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (arb_lost) begin
                    gnt_d  = '0;
                    lost_d = 1'b1;
                end else if (mst_done) begin
                    gnt_d  = '0;
                    last_d = owner;
                end else if (wd_hit) begin
                    gnt_d  = '0;
                    tout_d = 1'b1;
                    last_d = owner;
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_bus_sched.sv
// Bench for i2c_bus_sched (NREQ=2, BUF_CYC=4, TOUT_CYC=16): directed stimulus queues expected output events,
// a negedge monitor matches every gnt change / pulse (and timed snapshots) against that queue.
module tb_i2c_bus_sched;

    localparam int END_CYC = 150;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       bby, sto, mst_done, arb_lost;
    logic [1:0] gnt;
    logic [2:0] owner;
    logic       mst_go, lost, tout;

    i2c_bus_sched #(
        .NREQ    (2),
        .BUF_CYC (4),
        .TOUT_CYC(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .bby     (bby),
        .sto     (sto),
        .mst_done(mst_done),
        .arb_lost(arb_lost),
        .gnt     (gnt),
        .owner   (owner),
        .mst_go  (mst_go),
        .lost    (lost),
        .tout    (tout)
    );

    typedef struct {
        string      name;
        bit         snap;
        int         cyc;
        logic [1:0] gnt;
        logic [2:0] owner;
        logic       go;
        logic       ls;
        logic       to;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [1:0] prev_gnt = 2'b00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string nm, input bit snap, input int c, input logic [1:0] g,
                        input logic [2:0] o, input logic go, input logic ls, input logic to);
        exp_t e;
        e.name  = nm;
        e.snap  = snap;
        e.cyc   = c;
        e.gnt   = g;
        e.owner = o;
        e.go    = go;
        e.ls    = ls;
        e.to    = to;
        q.push_back(e);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit match(input exp_t e);
        if (gnt !== e.gnt || mst_go !== e.go || lost !== e.ls || tout !== e.to) return 1'b0;
        if (e.gnt != 2'b00 && owner !== e.owner) return 1'b0;
        return 1'b1;
    endfunction

    // Stimulus: every absolute cycle below is hand-derived for BUF_CYC=4.
    initial begin
        rst_n = 1'b0; req = 2'b00; bby = 1'b0; sto = 1'b0; mst_done = 1'b0; arb_lost = 1'b0;
        push("reset_state", 1, 3, 2'b00, 3'd0, 0, 0, 0);
        goto(3); rst_n = 1'b1;

        // Single requester, bus long idle: 1-cycle grant, release, guarded re-grant.
        goto(11); req = 2'b01;
        push("t1_grant", 0, 12, 2'b01, 3'd0, 1, 0, 0);
        goto(14); mst_done = 1'b1;
        push("t1_release", 0, 15, 2'b00, 3'd0, 0, 0, 0);
        goto(15); mst_done = 1'b0;
        push("t1_regrant", 0, 20, 2'b01, 3'd0, 1, 0, 0);

        // Both requesting: round-robin alternation.
        goto(22); req = 2'b11; mst_done = 1'b1;
        push("t2_rel0", 0, 23, 2'b00, 3'd0, 0, 0, 0);
        goto(23); mst_done = 1'b0;
        push("t2_gnt1", 0, 28, 2'b10, 3'd1, 1, 0, 0);
        goto(30); mst_done = 1'b1;
        push("t2_rel1", 0, 31, 2'b00, 3'd0, 0, 0, 0);
        goto(31); mst_done = 1'b0;
        push("t2_gnt0", 0, 36, 2'b01, 3'd0, 1, 0, 0);
        goto(38); mst_done = 1'b1;
        push("t2_rel2", 0, 39, 2'b00, 3'd0, 0, 0, 0);
        goto(39); mst_done = 1'b0;
        push("t2_gnt1b", 0, 44, 2'b10, 3'd1, 1, 0, 0);

        // Owner 1 loses arbitration; wait for STOP, then loser keeps priority.
        goto(46); arb_lost = 1'b1; bby = 1'b1;
        push("t3_lost", 0, 47, 2'b00, 3'd0, 0, 1, 0);
        goto(47); arb_lost = 1'b0;
        goto(52); sto = 1'b1;
        goto(53); sto = 1'b0; bby = 1'b0;
        push("t3_regrant1", 0, 58, 2'b10, 3'd1, 1, 0, 0);

        // Bus busy after release, then a bby glitch restarts the bus-free count.
        goto(60); mst_done = 1'b1; bby = 1'b1; req = 2'b01;
        push("t4_release", 0, 61, 2'b00, 3'd0, 0, 0, 0);
        goto(61); mst_done = 1'b0;
        goto(66); bby = 1'b0;
        goto(69); bby = 1'b1;
        goto(70); bby = 1'b0;
        push("t4_bus_free_grant", 0, 75, 2'b01, 3'd0, 1, 0, 0);

        // Done and lost together: loss wins, last stays at requester 1.
        goto(77); req = 2'b11; mst_done = 1'b1; arb_lost = 1'b1;
        push("t5_lost_wins", 0, 78, 2'b00, 3'd0, 0, 1, 0);
        goto(78); mst_done = 1'b0; arb_lost = 1'b0;
        push("t5_regrant0", 0, 84, 2'b01, 3'd0, 1, 0, 0);

        // Reset during ACTIVE drops gnt on the next edge; priority restarts at 0.
        goto(86); rst_n = 1'b0;
        push("t6_reset_drop", 0, 87, 2'b00, 3'd0, 0, 0, 0);
        goto(87); rst_n = 1'b1;
        push("t6_after_reset", 0, 92, 2'b01, 3'd0, 1, 0, 0);

        // Requester drops req early and never completes.
        goto(93); req = 2'b00;
`ifdef I2C_BUS_SCHED_WDOG_EN
        push("t7_timeout", 0, 108, 2'b00, 3'd0, 0, 0, 1);
        push("t7_after_timeout", 1, 140, 2'b00, 3'd0, 0, 0, 0);
`else
        push("t7_held", 1, 140, 2'b01, 3'd0, 0, 0, 0);
`endif
    end

    always @(negedge clk) begin
        exp_t e;
        bit   ev;

        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++; bad++;
            $display("FAIL %s: nothing observed at cyc=%0d, required gnt=%b owner=%0d go=%b lost=%b tout=%b",
                     e.name, e.cyc, e.gnt, e.owner, e.go, e.ls, e.to);
        end

        if (q.size() > 0 && q[0].snap && q[0].cyc == cyc) begin
            e = q.pop_front();
            total++;
            if (!match(e)) begin
                bad++;
                $display("FAIL %s cyc=%0d: got gnt=%b owner=%0d go=%b lost=%b tout=%b, required gnt=%b owner=%0d go=%b lost=%b tout=%b",
                         e.name, cyc, gnt, owner, mst_go, lost, tout, e.gnt, e.owner, e.go, e.ls, e.to);
            end
        end

        ev = (gnt !== prev_gnt) || (mst_go !== 1'b0) || (lost !== 1'b0) || (tout !== 1'b0);
        if (ev) begin
            if (q.size() == 0 || q[0].snap) begin
                total++; bad++;
                $display("FAIL unexpected_event cyc=%0d: got gnt=%b owner=%0d go=%b lost=%b tout=%b, required no change",
                         cyc, gnt, owner, mst_go, lost, tout);
            end else begin
                e = q.pop_front();
                total++;
                if (!match(e) || e.cyc != cyc) begin
                    bad++;
                    $display("FAIL %s: got cyc=%0d gnt=%b owner=%0d go=%b lost=%b tout=%b, required cyc=%0d gnt=%b owner=%0d go=%b lost=%b tout=%b",
                             e.name, cyc, gnt, owner, mst_go, lost, tout, e.cyc, e.gnt, e.owner, e.go, e.ls, e.to);
                end
            end
        end
        prev_gnt = gnt;

        if (cyc >= END_CYC) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                total++; bad++;
                $display("FAIL %s: never observed, required at cyc=%0d gnt=%b", e.name, e.cyc, e.gnt);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

endmodule

// File: doc/i2c_bus_sched.md
Name: i2c_bus_sched

Overview:
- Shares one I2C master core between NREQ local requesters on a multi-master bus.
- Consumes the bus-busy indication from the bus-busy detector (bby, sto).
- Enforces the bus-free time before any START and grants the core round-robin.
- Handles arbitration loss by backing off until the foreign master issues STOP.

Parameters:
- NREQ, 2: number of requesters; legal range 1..8.
- BUF_CYC, 64: minimum bus-free time in clk cycles before a grant; must be >= 1.
- TOUT_CYC, 65536: watchdog limit in clk cycles for one ACTIVE tenure; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- req  in  NREQ  per-requester request level; held until the matching gnt bit drops
- bby  in  1  bus busy from the bus-busy detector
- sto  in  1  STOP-detected pulse from the bus-busy detector
- mst_done  in  1  1-cycle pulse from the master core: transfer finished, STOP issued
- arb_lost  in  1  1-cycle pulse from the master core: arbitration lost
- gnt  out  NREQ  one-hot grant, registered
- owner  out  3  index of the granted requester; valid while gnt != 0
- mst_go  out  1  1-cycle pulse: master core may issue START for owner
- lost  out  1  1-cycle pulse mirroring an arbitration loss of the current owner
- tout  out  1  1-cycle watchdog pulse; tied 0 without the optional feature

Behaviour:
- Reset is synchronous on rst_n=0. Reset values:
  - gnt=0, owner=0, mst_go=0, lost=0, tout=0.
  - State=IDLE, idle_cnt=0, last=NREQ-1 (so requester 0 has first priority).
- idle_cnt:
  - Increments each cycle bby=0 and state=IDLE, saturating at BUF_CYC.
  - Cleared to 0 in any cycle where bby=1 or state!=IDLE.
  - Width = ceil(log2(BUF_CYC+1)), computed with a constant function.
- IDLE:
  - When req!=0, bby=0 and idle_cnt==BUF_CYC: pick the first set req bit searching upward from last+1 with wrap.
  - In the next cycle: gnt=onehot(pick), owner=pick, mst_go=1, state=ACTIVE.
  - Latency: 1 cycle if the bus has already been idle BUF_CYC cycles; otherwise BUF_CYC+1 cycles after bby falls.
- ACTIVE:
  - gnt is held regardless of req; a requester dropping req early is ignored.
  - mst_done: next cycle gnt=0, last=owner, state=IDLE.
  - arb_lost: next cycle gnt=0, lost=1, last unchanged (loser keeps priority), state=BACKOFF.
  - mst_done and arb_lost in the same cycle: arb_lost wins.
- BACKOFF:
  - gnt=0.
  - Leaves to IDLE on the cycle after sto=1, or after bby=0 is seen on any cycle (covers a missed STOP).
  - idle_cnt then restarts from 0.
- Changes to req while a grant is pending in IDLE: the pick is evaluated on the grant cycle only. No grant is issued if req becomes 0 that cycle.
- bby rising in IDLE on the same cycle as the grant condition: grant is suppressed. The condition requires bby=0 that cycle.
- mst_go, lost and tout never assert in the same cycle.
- rst_n low mid-ACTIVE: gnt drops on the next edge. The master core is reset by the same rst_n.

Optional Feature:
- Macro I2C_BUS_SCHED_WDOG_EN.
- Defined:
  - A counter runs while state=ACTIVE.
  - Reaching TOUT_CYC-1 without mst_done or arb_lost: next cycle gnt=0, tout=1, last=owner, state=BACKOFF.
  - mst_done or arb_lost on the terminal-count cycle takes precedence over the timeout.
- Not defined: no counter, tout tied 0, ACTIVE unbounded.

Test Plan:
- BUF_CYC=4, bby=0 long, req=01 -> gnt=01 with mst_go one cycle later; mst_done -> gnt=00 next cycle; re-grant only after 4 idle cycles.
- req=11 held, three done cycles -> grant order 01,10,01; owner 0,1,0.
- bby=1 with req=01, bby falls at cycle t -> gnt rises at t+BUF_CYC+1. Raising bby during the count -> no grant, count restarts.
- Owner 1 active, arb_lost -> lost=1, gnt=00. No grant until sto pulse plus BUF_CYC idle. Then req=11 grants requester 1 again.
- mst_done and arb_lost same cycle -> lost=1, state BACKOFF. rst_n=0 during ACTIVE -> gnt=00 next edge.
- With I2C_BUS_SCHED_WDOG_EN, TOUT_CYC=16, no done -> tout=1 at cycle 16 of ACTIVE, gnt=00. Without the macro -> gnt held indefinitely, tout=0.
